apb_reg_target: RTL and testbench

- APB completer register bank that sits directly downstream of the APB address decoder, on one of its per-sub-block APB ports.
- Holds NUM_REGS word-wide registers. Read-write registers drive control outputs; read-only registers return live status inputs.
- Supports programmable wait states and flags protocol and address errors via pslverr.
- Tolerates the decoder behaviour of holding psel until pready and gating penable with psel.

---
 rtl/apb_reg_target_if.sv | 30 +++
 rtl/apb_reg_target.sv | 187 ++++++++++++++++++
 tb/tb_apb_reg_target.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_reg_target_if.sv
// APB completer-side bus bundle for apb_reg_target.
// Carries pstrb only when APB_TGT_PSTRB_EN is defined.
interface apb_reg_target_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
`ifdef APB_TGT_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb;
`endif
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

`ifdef APB_TGT_PSTRB_EN
    modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                    input  pready, prdata, pslverr);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                    output pready, prdata, pslverr);
`else
    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  pready, prdata, pslverr);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output pready, prdata, pslverr);
`endif
endinterface

// File: rtl/apb_reg_target.sv
// APB completer register bank: RW control words, RO status words, wait states, pslverr.
// Define APB_TGT_PSTRB_EN to add byte-strobed writes (pstrb in the bus interface).
//
// state  | meaning
// S_IDLE | waiting for psel & penable; latches the access
// S_WAIT | down-counting wait states; psel low aborts the access
// S_RESP | one-cycle pready with registered prdata / pslverr / wr_pulse
module apb_reg_target #(
    parameter int                  NUM_REGS    = 16,
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR   = '0,
    parameter int                  WAIT_CYCLES = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    apb_reg_target_if.slave            bus,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]        wr_pulse,
    input  logic [NUM_REGS*DATA_W-1:0] status_in
);
    localparam int         IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                write_q;
    logic [DATA_W-1:0]   regs_q   [NUM_REGS];
    logic [DATA_W-1:0]   status_w [NUM_REGS];

    logic                pready_q;
    logic                pslverr_q;
    logic [DATA_W-1:0]   prdata_q;
    logic [NUM_REGS-1:0] wr_pulse_q;

    logic                start;
    logic                go_resp;

    logic [ADDR_W-1:0]   acc_addr;
    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   idx_full;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   acc_wdata;
    logic [DATA_W-1:0]   wr_word;
    logic [DATA_W-1:0]   rd_word;
    logic                acc_write;
    logic                in_range;
    logic                ro_hit;
    logic                err;
    logic                wr_any;
`ifdef APB_TGT_PSTRB_EN
    logic [DATA_W/8-1:0] strb_q;
    logic [DATA_W/8-1:0] acc_strb;
`endif

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_words
        assign reg_out[i*DATA_W +: DATA_W] = regs_q[i];
        assign status_w[i] = status_in[i*DATA_W +: DATA_W];
    end

    assign bus.pready  = pready_q;
    assign bus.prdata  = prdata_q;
    assign bus.pslverr = pslverr_q;
    assign wr_pulse    = wr_pulse_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        go_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.psel && bus.penable) begin
                    start = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    go_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the response edge is also the capture edge, so decode the live bus in IDLE.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_addr  = bus.paddr;
            acc_wdata = bus.pwdata;
            acc_write = bus.pwrite;
`ifdef APB_TGT_PSTRB_EN
            acc_strb  = bus.pstrb;
`endif
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_write = write_q;
`ifdef APB_TGT_PSTRB_EN
            acc_strb  = strb_q;
`endif
        end
        offset   = acc_addr - BASE_ADDR;
        idx_full = offset >> 2;
        idx      = idx_full[IDX_W-1:0];
        in_range = (acc_addr >= BASE_ADDR) && (idx_full < ADDR_W'(NUM_REGS));
        ro_hit   = in_range && RO_MASK[idx];
        err      = (acc_addr[1:0] != 2'b00) || !in_range || (acc_write && ro_hit);
        rd_word  = ro_hit ? status_w[idx] : regs_q[idx];
        wr_word  = acc_wdata;
`ifdef APB_TGT_PSTRB_EN
        err      = err || (!acc_write && (acc_strb != '0));
        wr_any   = |acc_strb;
        for (int b = 0; b < DATA_W/8; b++) begin
            wr_word[b*8 +: 8] = acc_strb[b] ? acc_wdata[b*8 +: 8] : regs_q[idx][b*8 +: 8];
        end
`else
        wr_any   = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
`ifdef APB_TGT_PSTRB_EN
            strb_q     <= '0;
`endif
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pready_q   <= go_resp;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            if (start) begin
                addr_q  <= bus.paddr;
                wdata_q <= bus.pwdata;
                write_q <= bus.pwrite;
`ifdef APB_TGT_PSTRB_EN
                strb_q  <= bus.pstrb;
`endif
                cnt_q   <= CNT_LOAD;
            end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (go_resp) begin
                pslverr_q <= err;
                if (!acc_write) begin
                    prdata_q <= err ? '0 : rd_word;
                end else if (!err && wr_any) begin
                    regs_q[idx]     <= wr_word;
                    wr_pulse_q[idx] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_reg_target.sv
// Self-checking bench for apb_reg_target: two instances (1 and 3 wait states) against a word-array model.
// Byte-strobe steps are included when APB_TGT_PSTRB_EN is defined.
module tb_apb_reg_target;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0000_1000;
    localparam logic [15:0] RO_A   = 16'h0001;
    localparam logic [15:0] RO_B   = 16'h8010;
    localparam int          WAIT_A = 1;
    localparam int          WAIT_B = 3;

    logic         clk;
    logic         rst_n;
    logic         psel;
    logic         penable;
    logic         pwrite;
    logic [31:0]  paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    int           sel;
    logic [511:0] stat_a;
    logic [511:0] stat_b;
    logic [511:0] regs_a;
    logic [511:0] regs_b;
    logic [15:0]  wp_a;
    logic [15:0]  wp_b;

    int           vectors;
    int           miscompares;
    logic [31:0]  mdl [2][16];

    apb_reg_target_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    apb_reg_target_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

    assign bus_a.psel    = psel && (sel == 0);
    assign bus_b.psel    = psel && (sel == 1);
    assign bus_a.penable = penable && psel && (sel == 0);
    assign bus_b.penable = penable && psel && (sel == 1);
    assign bus_a.pwrite  = pwrite;
    assign bus_b.pwrite  = pwrite;
    assign bus_a.paddr   = paddr;
    assign bus_b.paddr   = paddr;
    assign bus_a.pwdata  = pwdata;
    assign bus_b.pwdata  = pwdata;
`ifdef APB_TGT_PSTRB_EN
    assign bus_a.pstrb   = pstrb;
    assign bus_b.pstrb   = pstrb;
`endif

    apb_reg_target #(.NUM_REGS(16), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE_A),
                     .WAIT_CYCLES(WAIT_A), .RO_MASK(RO_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
        .reg_out(regs_a), .wr_pulse(wp_a), .status_in(stat_a));

    apb_reg_target #(.NUM_REGS(16), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE_B),
                     .WAIT_CYCLES(WAIT_B), .RO_MASK(RO_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
        .reg_out(regs_b), .wr_pulse(wp_b), .status_in(stat_b));

    wire         pready_o  = (sel == 0) ? bus_a.pready  : bus_b.pready;
    wire         pslverr_o = (sel == 0) ? bus_a.pslverr : bus_b.pslverr;
    wire [31:0]  prdata_o  = (sel == 0) ? bus_a.prdata  : bus_b.prdata;
    wire [15:0]  wp_o      = (sel == 0) ? wp_a : wp_b;
    wire [511:0] regs_o    = (sel == 0) ? regs_a : regs_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] model_vec(input int s);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = mdl[s][i];
        return v;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) mdl[s][i] = 32'h0;
    endtask

    // One full APB transfer on instance s with expectations derived from the register-map rules.
    task automatic do_txn(input int s, input logic [31:0] addr, input logic wr,
                          input logic [31:0] data, input logic [3:0] strb, input string tag);
        logic [31:0] base;
        logic [15:0] ro;
        longint      off;
        int          idx;
        int          exp_lat;
        int          lat;
        logic        e;
        logic [31:0] erd;
        logic [15:0] ewp;
        logic [31:0] nw;
        logic [31:0] sw;
        logic        got_err;
        logic [31:0] got_rd;
        logic [15:0] got_wp;
        logic [511:0] got_regs;

        base    = (s == 0) ? BASE_A : BASE_B;
        ro      = (s == 0) ? RO_A : RO_B;
        exp_lat = 1 + ((s == 0) ? WAIT_A : WAIT_B);
        off     = longint'(addr) - longint'(base);
        e       = (off < 0) || (off % 4 != 0) || (off / 4 >= 16);
        idx     = e ? 0 : int'(off / 4);
        if (!e && wr && ro[idx]) e = 1'b1;
`ifdef APB_TGT_PSTRB_EN
        if (!wr && strb != 4'h0) e = 1'b1;
`endif
        sw  = (s == 0) ? stat_a[idx*32 +: 32] : stat_b[idx*32 +: 32];
        erd = 32'h0;
        ewp = 16'h0;
        if (!e && !wr) erd = ro[idx] ? sw : mdl[s][idx];
        if (!e && wr) begin
`ifdef APB_TGT_PSTRB_EN
            nw = mdl[s][idx];
            for (int b = 0; b < 4; b++) if (strb[b]) nw[b*8 +: 8] = data[b*8 +: 8];
            if (strb != 4'h0) begin
                mdl[s][idx] = nw;
                ewp[idx] = 1'b1;
            end
`else
            nw = data;
            mdl[s][idx] = nw;
            ewp[idx] = 1'b1;
`endif
        end

        @(negedge clk);
        sel = s; paddr = addr; pwrite = wr; pwdata = data; pstrb = strb;
        psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        lat = 0;
        got_err = 1'bx; got_rd = 'x; got_wp = 'x; got_regs = 'x;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (pready_o) begin
                lat = k;
                got_err = pslverr_o; got_rd = prdata_o; got_wp = wp_o; got_regs = regs_o;
                break;
            end
        end
        psel = 1'b0; penable = 1'b0;

        check({tag, "_lat"}, 512'(lat), 512'(exp_lat));
        check({tag, "_pslverr"}, 512'(got_err), 512'(e));
        if (!wr) check({tag, "_prdata"}, 512'(got_rd), 512'(erd));
        check({tag, "_wr_pulse"}, 512'(got_wp), 512'(ewp));
        check({tag, "_reg_out"}, got_regs, model_vec(s));
        @(negedge clk);
        check({tag, "_pulse_end"}, 512'({pready_o, wp_o}), 512'(0));
    endtask

    task automatic do_abort(input logic [31:0] addr, input logic [31:0] data);
        int seen;
        @(negedge clk);
        sel = 1; paddr = addr; pwrite = 1'b1; pwdata = data; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        seen = 0;
        @(negedge clk);
        if (bus_b.pready || wp_b != 16'h0) seen++;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus_b.pready || wp_b != 16'h0) seen++;
        end
        check("abort_no_pready", 512'(seen), 512'(0));
        check("abort_reg_out", regs_b, model_vec(1));
    endtask

    task automatic do_reset_in_wait(input logic [31:0] addr, input logic [31:0] data);
        int seen;
        @(negedge clk);
        sel = 1; paddr = addr; pwrite = 1'b1; pwdata = data; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus_b.pready) seen++;
        end
        rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus_b.pready || wp_b != 16'h0) seen++;
        end
        clear_model();
        check("rstwait_no_pready", 512'(seen), 512'(0));
        check("rstwait_regs_b", regs_b, 512'(0));
        check("rstwait_regs_a", regs_a, 512'(0));
    endtask

    initial begin
        int          kind;
        int          s;
        int          ridx;
        logic [31:0] base;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;

        vectors = 0; miscompares = 0;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = 4'hF; sel = 0;
        stat_a = '0; stat_b = '0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check("rst_outputs_a", 512'({bus_a.pready, bus_a.pslverr, bus_a.prdata, wp_a}), 512'(0));
        check("rst_outputs_b", 512'({bus_b.pready, bus_b.pslverr, bus_b.prdata, wp_b}), 512'(0));
        check("rst_regs_a", regs_a, 512'(0));
        check("rst_regs_b", regs_b, 512'(0));

        do_txn(0, 32'h0000_000C, 1'b0, 32'h0, 4'h0, "rd_reg3");
        do_txn(0, 32'h0000_0014, 1'b1, 32'hDEAD_BEEF, 4'hF, "wr_reg5");
        do_txn(0, 32'h0000_0014, 1'b0, 32'h0, 4'h0, "rdback_reg5");
        do_txn(0, 32'h0000_0041, 1'b1, 32'h1234_5678, 4'hF, "wr_misalign");
        do_txn(0, 32'h0000_0041, 1'b0, 32'h0, 4'h0, "rd_misalign");
        do_txn(0, 32'h0000_0040, 1'b0, 32'h0, 4'h0, "rd_oor");
        do_txn(0, 32'h0000_003C, 1'b1, 32'h0BAD_F00D, 4'hF, "wr_last");
        stat_a[31:0] = 32'h0000_1234;
        do_txn(0, 32'h0000_0000, 1'b0, 32'h0, 4'h0, "rd_ro0");
        do_txn(0, 32'h0000_0000, 1'b1, 32'h0000_FFFF, 4'hF, "wr_ro0");

        do_txn(1, 32'h0000_1004, 1'b1, 32'hCAFE_F00D, 4'hF, "b_wr_reg1");
        do_txn(1, 32'h0000_0FFC, 1'b0, 32'h0, 4'h0, "b_rd_below");
        do_abort(32'h0000_1004, 32'h5555_5555);
        do_txn(1, 32'h0000_1004, 1'b0, 32'h0, 4'h0, "b_after_abort");
        do_txn(1, 32'h0000_1008, 1'b1, 32'h7777_0001, 4'hF, "b_wr_reg2");
        do_reset_in_wait(32'h0000_1008, 32'h9999_9999);

`ifdef APB_TGT_PSTRB_EN
        do_txn(0, 32'h0000_0008, 1'b1, 32'h1122_3344, 4'hF, "strb_init");
        do_txn(0, 32'h0000_0008, 1'b1, 32'hAABB_CCDD, 4'b0101, "strb_merge");
        do_txn(0, 32'h0000_0008, 1'b0, 32'h0, 4'h0, "strb_rdback");
        do_txn(0, 32'h0000_0008, 1'b0, 32'h0, 4'b0001, "strb_rd_err");
        do_txn(0, 32'h0000_0008, 1'b1, 32'hFFFF_FFFF, 4'h0, "strb_zero");
`endif

        for (int n = 0; n < 80; n++) begin
            for (int w = 0; w < 16; w++) begin
                stat_a[w*32 +: 32] = $urandom();
                stat_b[w*32 +: 32] = $urandom();
            end
            s    = int'($urandom_range(0, 1));
            base = (s == 0) ? BASE_A : BASE_B;
            kind = int'($urandom_range(0, 9));
            ridx = int'($urandom_range(0, 15));
            case (kind)
                6:       addr = base + 32'(ridx * 4) + 32'($urandom_range(1, 3));
                7:       addr = base + 32'($urandom_range(16, 20) * 4);
                8:       addr = base - 32'($urandom_range(1, 4) * 4);
                default: addr = base + 32'(ridx * 4);
            endcase
            wr = 1'($urandom_range(0, 1));
`ifdef APB_TGT_PSTRB_EN
            if (wr) strb = 4'($urandom_range(0, 15));
            else    strb = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
`else
            strb = 4'hF;
`endif
            do_txn(s, addr, wr, $urandom(), strb, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
